serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial integer adder sequencer. It time-shares one instance of the team's 1-bit full_adder cell across WIDTH cycles, LSB first, keeping the carry in a flip-flop between bits. Operands are accepted on a valid/ready input handshake, and the result is presented on a valid/ready output handshake. It is the low-area alternative to the ripple/parallel adders in the integer-arithmetic adder group.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a, b, cin are presented.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A (two's complement or unsigned).
b  input  WIDTH  operand B.
cin  input  1  carry-in to bit 0.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset is synchronous and dominates all other inputs. While rst is high at a rising edge: state <= IDLE, out_valid=0, sum=0, cout=0, ovf=0, busy=0, and all internal shift/carry/count registers are cleared. in_ready is 0 while rst is high.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On the edge where in_valid&&in_ready: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - a, b and cin are sampled only at this edge; changes at any other time are ignored.
- RUN (exactly WIDTH cycles):
  - in_ready=0, busy=1.
  - The full_adder cell inputs are A=a_sh[0], B=b_sh[0], Cin=carry.
  - Each edge: S is shifted into the MSB of sum_sh (right shift), carry<=Cout, a_sh and b_sh shift right, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: carry is also copied to c_msb_in before update, i.e. the carry into the MSB. Then state<=DONE, sum<=final sum_sh, cout<=Cout, ovf<=c_msb_in^Cout, out_valid<=1.
- DONE:
  - in_ready=0, busy=1, out_valid=1.
  - sum, cout and ovf stay stable for as long as out_ready=0.
  - On the edge where out_valid&&out_ready: out_valid<=0, sum/cout/ovf<=0, state<=IDLE.
- Outputs sum/cout/ovf are 0 whenever out_valid=0. They are registered, with no combinational path from inputs.
- Latency: if the accept edge is E0, out_valid goes high after edge E_WIDTH.
- Throughput: with out_ready tied high, one operation per WIDTH+2 cycles. The block does not accept a new input in the same cycle a result is consumed.
- in_valid asserted during RUN or DONE is not captured and is not queued. The producer must hold its request until in_ready is high.
- out_ready asserted in IDLE or RUN has no effect.
- Reset during RUN or DONE aborts the operation and no out_valid is produced. The next accepted operation computes correctly with no residue of the aborted carry.
- Unsigned and signed interpretation is the caller's choice: cout is the unsigned overflow flag and ovf is the signed overflow flag.
- Arithmetic is exact: {cout,sum} == a + b + cin for all inputs.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, sum=0, cout=0, ovf=0, busy=0. The cycle after release -> in_ready=1, and nothing has been captured.
2. WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid rises exactly 8 edges after accept with sum=0x96, cout=0, ovf=1. out_valid is high for one cycle, then in_ready=1 one cycle later.
3. WIDTH=8 corner operands, one check per operation:
   - a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
   - a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
   - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
4. Backpressure: a=0x12, b=0x34, hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a=0xAA -> sum stays 0x46, out_valid stays 1, in_ready stays 0. Then out_ready=1 -> IDLE on the next edge, and the 0xAA operation is accepted only after in_ready=1.
5. Reset mid-operation: accept a=0xF0, b=0x0F, then assert rst for 1 cycle during the 4th RUN cycle -> no out_valid ever appears. A following a=0x01, b=0x01, cin=0 -> sum=0x02, cout=0, ovf=0.
6. Exhaustive sweep with WIDTH=4: all 512 (a,b,cin) combinations with random out_ready stalls -> {cout,sum}==a+b+cin. ovf matches the signed reference. Every result appears 4 edges after its accept.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial integer adder sequencer.
// One full_adder cell is reused for WIDTH cycles, LSB first, with the
// carry held in a flip-flop between bits. Operands arrive on a
// valid/ready input handshake; the result leaves on a valid/ready
// output handshake.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_s;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic             w_consume;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Sum bits collected so far sit in r_sum_sh; the new bit enters at the MSB.
    assign w_sum_next = {w_s, r_sum_sh};

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_LAST);
    assign w_consume = r_out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)  w_next_state = S_RUN;
            S_RUN:  if (w_last)    w_next_state = S_DONE;
            S_DONE: if (w_consume) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand shifters, carry/count registers and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next[WIDTH-1:1];
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (w_last) begin
                        // r_carry here is the carry into the MSB, so no
                        // separate c_msb_in copy is needed for the overflow.
                        r_sum       <= w_sum_next;
                        r_cout      <= w_cout;
                        r_ovf       <= r_carry ^ w_cout;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_consume) begin
                        r_out_valid <= 1'b0;
                        r_sum       <= '0;
                        r_cout      <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
